// File: rtl/snax_csr_responder_pkg.sv
// -----------------------------------------------------------------------------
// snax_csr_responder_pkg
// Shared constants and types for the SNAX CSR responder.
//   - Address offsets of the control, status and performance CSRs, relative to
//     the first address after the RW and RO register blocks.
//   - Bit positions inside the control and status words.
//   - Launch FSM state encoding.
//   - Saturating increment used by the optional busy-cycle counter.
// -----------------------------------------------------------------------------
package snax_csr_responder_pkg;

  // Offsets added to (NumRwCsr + NumRoCsr) to form the special CSR addresses
  localparam int unsigned CtrlOffset   = 0;
  localparam int unsigned StatusOffset = 1;
  localparam int unsigned PerfOffset   = 2;

  // Control word: bit0 requests a launch
  localparam int unsigned CtrlStartBit = 0;

  // Status word: bit0 accelerator busy, bit1 launch pending
  localparam int unsigned StatusBusyBit = 0;
  localparam int unsigned StatusPendBit = 1;

  localparam int unsigned PerfWidth = 32;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LAUNCH = 1'b1
  } state_e;

  // Increment that sticks at the all-ones value instead of wrapping
  function automatic logic [PerfWidth-1:0] sat_inc(input logic [PerfWidth-1:0] value);
    if (&value) begin
      return value;
    end else begin
      return value + PerfWidth'(1);
    end
  endfunction

endpackage

// File: rtl/fifo_v3.sv
// -----------------------------------------------------------------------------
// fifo_v3
// Synchronous FIFO with the common_cells fifo_v3 parameter set, reduced to the
// ports the CSR responder needs.
// Parameters:
//   FALL_THROUGH  1: data_i visible on data_o when empty; 0: registered only
//   DATA_WIDTH    entry width
//   DEPTH         number of entries (>=1, need not be a power of two)
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   flush_i         synchronous clear of all entries
//   full_o, empty_o occupancy flags
//   data_i, push_i  write side (push ignored when full)
//   data_o, pop_i   read side (pop ignored when empty)
// -----------------------------------------------------------------------------
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  output logic                  full_o,
  output logic                  empty_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [PtrW-1:0]       wptr_r;
  logic [PtrW-1:0]       rptr_r;
  logic [CntW-1:0]       cnt_r;
  logic                  do_push_s;
  logic                  do_pop_s;
  logic                  bypass_s;

  // Wrap a pointer at DEPTH-1 so non-power-of-two depths work
  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
    if (ptr == PtrW'(DEPTH - 1)) begin
      return '0;
    end else begin
      return ptr + PtrW'(1);
    end
  endfunction

  // Flags, fall-through bypass and read data
  always_comb begin
    full_o    = (cnt_r == CntW'(DEPTH));
    empty_o   = (cnt_r == '0) && !(FALL_THROUGH && push_i);
    bypass_s  = FALL_THROUGH && (cnt_r == '0) && push_i && pop_i;
    do_push_s = push_i && !full_o && !bypass_s;
    do_pop_s  = pop_i && (cnt_r != '0);
    if (FALL_THROUGH && (cnt_r == '0)) begin
      data_o = data_i;
    end else begin
      data_o = mem_r[rptr_r];
    end
  end

  // Storage, pointers and occupancy count
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_r <= '0;
      rptr_r <= '0;
      cnt_r  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_r[i] <= '0;
      end
    end else if (flush_i) begin
      wptr_r <= '0;
      rptr_r <= '0;
      cnt_r  <= '0;
    end else begin
      if (do_push_s) begin
        mem_r[wptr_r] <= data_i;
        wptr_r        <= next_ptr(wptr_r);
      end
      if (do_pop_s) begin
        rptr_r <= next_ptr(rptr_r);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   cnt_r <= cnt_r + CntW'(1);
        2'b01:   cnt_r <= cnt_r - CntW'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

endmodule

// File: rtl/snax_csr_responder.sv
// -----------------------------------------------------------------------------
// snax_csr_responder
// Target end of the SNAX CSR request/response channel. Holds the accelerator's
// RW configuration bank, serves reads (RW, RO, status, perf) through an
// in-order response buffer and hands the RW bank to the accelerator with a
// valid/ready launch handshake.
// Optional feature: define SNAX_CSR_RESPONDER_PERF_EN to add a 32-bit saturating
// busy-cycle counter readable at PerfAddr; otherwise PerfAddr reads 0.
// Ports:
//   clk_i, rst_ni                       clock, asynchronous active-low reset
//   csr_req_{addr,data,write,valid}_i   request channel, csr_req_ready_o back
//   csr_rsp_{data,valid}_o              read response channel, csr_rsp_ready_i back
//   csr_rw_set_o                        RW bank, CSR i at [i*DataWidth +: DataWidth]
//   csr_rw_set_valid_o / _ready_i       launch handshake
//   csr_ro_set_i                        read-only values from the accelerator
//   acc_busy_i                          accelerator running
// -----------------------------------------------------------------------------
module snax_csr_responder
  import snax_csr_responder_pkg::*;
#(
  parameter int unsigned NumRwCsr  = 8,
  parameter int unsigned NumRoCsr  = 2,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned RspDepth  = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [AddrWidth-1:0]          csr_req_addr_i,
  input  logic [DataWidth-1:0]          csr_req_data_i,
  input  logic                          csr_req_write_i,
  input  logic                          csr_req_valid_i,
  output logic                          csr_req_ready_o,
  output logic [DataWidth-1:0]          csr_rsp_data_o,
  output logic                          csr_rsp_valid_o,
  input  logic                          csr_rsp_ready_i,
  output logic [NumRwCsr*DataWidth-1:0] csr_rw_set_o,
  output logic                          csr_rw_set_valid_o,
  input  logic                          csr_rw_set_ready_i,
  input  logic [NumRoCsr*DataWidth-1:0] csr_ro_set_i,
  input  logic                          acc_busy_i
);

  localparam int unsigned RwIdxW = (NumRwCsr > 1) ? $clog2(NumRwCsr) : 1;
  localparam int unsigned RoIdxW = (NumRoCsr > 1) ? $clog2(NumRoCsr) : 1;

  localparam logic [AddrWidth-1:0] RoBase     = AddrWidth'(NumRwCsr);
  localparam logic [AddrWidth-1:0] RoEnd      = AddrWidth'(NumRwCsr + NumRoCsr);
  localparam logic [AddrWidth-1:0] CtrlAddr   = AddrWidth'(NumRwCsr + NumRoCsr + CtrlOffset);
  localparam logic [AddrWidth-1:0] StatusAddr = AddrWidth'(NumRwCsr + NumRoCsr + StatusOffset);
  localparam logic [AddrWidth-1:0] PerfAddr   = AddrWidth'(NumRwCsr + NumRoCsr + PerfOffset);

  logic [DataWidth-1:0] rw_bank_r [NumRwCsr];
  logic [DataWidth-1:0] ro_arr_s  [NumRoCsr];
  state_e               state_r;
  logic                 set_valid_r;
  logic                 rst_done_r;

  logic                 is_rw_s;
  logic                 is_ro_s;
  logic                 is_ctrl_s;
  logic                 is_status_s;
  logic                 is_perf_s;
  logic [RwIdxW-1:0]    rw_idx_s;
  logic [RoIdxW-1:0]    ro_idx_s;
  logic                 stall_s;
  logic                 req_fire_s;
  logic                 launch_fire_s;
  logic [DataWidth-1:0] status_s;
  logic [DataWidth-1:0] perf_rd_s;
  logic [DataWidth-1:0] rd_data_s;

  logic                 fifo_full_s;
  logic                 fifo_empty_s;
  logic                 fifo_push_s;
  logic                 fifo_pop_s;
  logic [DataWidth-1:0] fifo_data_s;

  for (genvar i = 0; i < int'(NumRoCsr); i++) begin : g_ro_unpack
    assign ro_arr_s[i] = csr_ro_set_i[i*DataWidth +: DataWidth];
  end

  for (genvar i = 0; i < int'(NumRwCsr); i++) begin : g_rw_pack
    assign csr_rw_set_o[i*DataWidth +: DataWidth] = rw_bank_r[i];
  end

  // Address decode, acceptance and launch handshake
  always_comb begin
    is_rw_s       = (csr_req_addr_i < RoBase);
    is_ro_s       = (csr_req_addr_i >= RoBase) && (csr_req_addr_i < RoEnd);
    is_ctrl_s     = (csr_req_addr_i == CtrlAddr);
    is_status_s   = (csr_req_addr_i == StatusAddr);
    is_perf_s     = (csr_req_addr_i == PerfAddr);
    rw_idx_s      = csr_req_addr_i[RwIdxW-1:0];
    ro_idx_s      = RoIdxW'(csr_req_addr_i - RoBase);
    // While the bank is offered to the accelerator it must not change, so
    // writes that could alter it (RW or another start) wait; reads never do.
    stall_s       = (state_r == LAUNCH) && csr_req_write_i && (is_rw_s || is_ctrl_s);
    // No pop bypass: a full buffer blocks every request, writes included.
    csr_req_ready_o = rst_done_r && !fifo_full_s && !stall_s;
    req_fire_s    = csr_req_valid_i && csr_req_ready_o;
    launch_fire_s = set_valid_r && csr_rw_set_ready_i;
  end

  // Status word and read-data mux, sampled in the accept cycle
  always_comb begin
    status_s                = '0;
    status_s[StatusBusyBit] = acc_busy_i;
    status_s[StatusPendBit] = (state_r == LAUNCH);
    if (is_rw_s) begin
      rd_data_s = rw_bank_r[rw_idx_s];
    end else if (is_ro_s) begin
      rd_data_s = ro_arr_s[ro_idx_s];
    end else if (is_status_s) begin
      rd_data_s = status_s;
    end else if (is_perf_s) begin
      rd_data_s = perf_rd_s;
    end else begin
      rd_data_s = '0;
    end
  end

  // Request channel opens only after the first clock out of reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rst_done_r <= 1'b0;
    end else begin
      rst_done_r <= 1'b1;
    end
  end

  // RW configuration bank
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NumRwCsr); i++) begin
        rw_bank_r[i] <= '0;
      end
    end else if (req_fire_s && csr_req_write_i && is_rw_s) begin
      rw_bank_r[rw_idx_s] <= csr_req_data_i;
    end
  end

  // Launch FSM with registered handshake valid
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= IDLE;
      set_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_fire_s && csr_req_write_i && is_ctrl_s && csr_req_data_i[CtrlStartBit]) begin
            state_r     <= LAUNCH;
            set_valid_r <= 1'b1;
          end
        end
        LAUNCH: begin
          if (launch_fire_s) begin
            state_r     <= IDLE;
            set_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= IDLE;
          set_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign csr_rw_set_valid_o = set_valid_r;

`ifdef SNAX_CSR_RESPONDER_PERF_EN
  logic [PerfWidth-1:0] perf_r;

  // Busy-cycle counter, restarted by each accepted launch
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_r <= '0;
    end else if (launch_fire_s) begin
      perf_r <= '0;
    end else if (acc_busy_i) begin
      perf_r <= sat_inc(perf_r);
    end
  end

  assign perf_rd_s = DataWidth'(perf_r);
`else
  assign perf_rd_s = '0;
`endif

  // Only reads produce responses
  assign fifo_push_s = req_fire_s && !csr_req_write_i;
  assign fifo_pop_s  = !fifo_empty_s && csr_rsp_ready_i;

  fifo_v3 #(
    .FALL_THROUGH (1'b0),
    .DATA_WIDTH   (DataWidth),
    .DEPTH        (RspDepth)
  ) i_rsp_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (1'b0),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .data_i  (rd_data_s),
    .push_i  (fifo_push_s),
    .data_o  (fifo_data_s),
    .pop_i   (fifo_pop_s)
  );

  assign csr_rsp_valid_o = !fifo_empty_s;
  assign csr_rsp_data_o  = fifo_empty_s ? '0 : fifo_data_s;

endmodule
